// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg : shared types and line levels for the transmit-only UART
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4
  } tx_state_t;

  localparam int DATA_BITS = 8;
  localparam int IDX_W     = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/baud_gen.sv
// ---------------------------------------------------------------------------
// baud_gen : free-running divider producing a one-clock tick every DIV clocks
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module baud_gen #(
  parameter int CLK_FREQ  = 100_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic clk,
  input  logic reset,
  output logic baud_tick
);

  localparam int DIV   = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W = (DIV < 2) ? 1 : $clog2(DIV);

  generate
    if (DIV < 2) begin : g_div_check
      $error("baud_gen: CLK_FREQ / BAUD_RATE must be at least 2");
    end
  endgenerate

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(DIV - 2);

  logic [CNT_W-1:0] cnt;

  // tick is registered one count early so it is high while cnt == DIV-1
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      baud_tick <= 1'b0;
    end else begin
      cnt       <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
      baud_tick <= (cnt == CNT_PRE);
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx : 8N1 transmit FSM, LSB-first, advancing only on baud ticks
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_tx
  import uart_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 send,
  output logic                 tx,
  output logic                 busy
);

  tx_state_t             state;
  logic [DATA_BITS-1:0]  shift;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      next_idx;

  assign next_idx = idx + IDX_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      tx    <= IDLE_LEVEL;
      busy  <= 1'b0;
      idx   <= '0;
      shift <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx <= IDLE_LEVEL;
          if (send) begin
            shift <= data_in;
            idx   <= '0;
            busy  <= 1'b1;
            state <= ALIGN;
          end
        end
        // ALIGN absorbs the arbitrary baud phase so every bit is a full DIV long
        ALIGN: begin
          if (baud_tick) begin
            tx    <= START_LEVEL;
            state <= START;
          end
        end
        START: begin
          if (baud_tick) begin
            tx    <= shift[0];
            idx   <= '0;
            state <= DATA;
          end
        end
        DATA: begin
          if (baud_tick) begin
            if (idx == LAST_IDX) begin
              tx    <= STOP_LEVEL;
              state <= STOP;
            end else begin
              idx <= next_idx;
              tx  <= shift[next_idx];
            end
          end
        end
        STOP: begin
          if (baud_tick) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          tx    <= IDLE_LEVEL;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_top.sv
// ---------------------------------------------------------------------------
// uart_tx_top : baud generator plus 8N1 transmitter; tick exported for sharing
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_tx_top
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 send,
  output logic                 tx,
  output logic                 busy,
  output logic                 baud_tick
);

  baud_gen #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) u_baud_gen (
    .clk       (clk),
    .reset     (reset),
    .baud_tick (baud_tick)
  );

  uart_tx u_uart_tx (
    .clk       (clk),
    .reset     (reset),
    .baud_tick (baud_tick),
    .data_in   (data_in),
    .send      (send),
    .tx        (tx),
    .busy      (busy)
  );

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_top.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_top : directed self-checking bench for uart_tx_top (DIV = 10)
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_uart_tx_top;

  localparam int DIV = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       send = 1'b0;
  logic       tx;
  logic       busy;
  logic       baud_tick;

  int checks = 0;
  int passes = 0;

  uart_tx_top #(
    .CLK_FREQ  (100_000),
    .BAUD_RATE (9600)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .send      (send),
    .tx        (tx),
    .busy      (busy),
    .baud_tick (baud_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Pulse send for one clock; busy must be high one cycle later.
  task automatic send_byte(input logic [7:0] d, input string name);
    @(negedge clk);
    data_in = d;
    send    = 1'b1;
    @(negedge clk);
    send    = 1'b0;
    checks++;
    if (busy !== 1'b1) $display("FAIL %s busy_after_send: got %b, required 1", name, busy);
    else passes++;
  endtask

  // Waits for the start edge; on return the current negedge is the first start-bit cycle.
  task automatic wait_start(input string name, output bit ok);
    int n;
    n  = 0;
    ok = 1'b0;
    while (n < 3 * DIV) begin
      @(negedge clk);
      n++;
      if (tx === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok || n > DIV)
      $display("FAIL %s start_latency: got %0d cycles (seen=%0b), required 1..%0d", name, n, ok, DIV);
    else passes++;
  endtask

  // exp[0] = start bit, exp[8:1] = data LSB first, exp[9] = stop bit.
  task automatic check_frame(input logic [9:0] exp, input string name, input bit inject);
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < DIV; c++) begin
        if (!(b == 0 && c == 0)) @(negedge clk);
        if (inject && b == 4 && c == 2) begin
          data_in = 8'hFF;
          send    = 1'b1;
        end
        if (inject && b == 4 && c == 3) send = 1'b0;
        if (c == 0 || c == DIV - 1) begin
          checks++;
          if (tx !== exp[b])
            $display("FAIL %s bit%0d cyc%0d: tx=%b, required %b", name, b, c, tx, exp[b]);
          else passes++;
        end
        if (b == 9 && c == DIV - 1) begin
          checks++;
          if (busy !== 1'b1) $display("FAIL %s busy_last_stop_cycle: got %b, required 1", name, busy);
          else passes++;
        end
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || tx !== 1'b1)
      $display("FAIL %s end_of_frame: busy=%b tx=%b, required busy=0 tx=1", name, busy, tx);
    else passes++;
  endtask

  task automatic tx_frame(input logic [7:0] d, input logic [9:0] exp, input string name);
    bit ok;
    send_byte(d, name);
    wait_start(name, ok);
    if (ok) check_frame(exp, name, 1'b0);
  endtask

  task automatic test_reset;
    int first;
    int second;
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || baud_tick !== 1'b0)
      $display("FAIL reset_values: tx=%b busy=%b tick=%b, required 1 0 0", tx, busy, baud_tick);
    else passes++;
    reset = 1'b1;
    // Tick is high while the counter sits at DIV-1, i.e. after DIV-1 edges,
    // and is consumed by the transmitter on the DIV-th edge after release.
    first  = -1;
    second = -1;
    for (int k = 1; k <= 3 * DIV; k++) begin
      @(negedge clk);
      if (baud_tick === 1'b1) begin
        if (first < 0) first = k;
        else if (second < 0) second = k;
      end
    end
    checks++;
    if (first + 1 != DIV) $display("FAIL first_tick_edge: got %0d, required %0d", first + 1, DIV);
    else passes++;
    checks++;
    if (second - first != DIV) $display("FAIL tick_period: got %0d, required %0d", second - first, DIV);
    else passes++;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0)
      $display("FAIL idle_after_reset: tx=%b busy=%b, required 1 0", tx, busy);
    else passes++;
  endtask

  task automatic test_single;
    tx_frame(8'h53, 10'b1010100110, "single_0x53");
  endtask

  task automatic test_back_to_back;
    tx_frame(8'h53, 10'b1010100110, "b2b_S");
    tx_frame(8'h45, 10'b1010001010, "b2b_E");
    tx_frame(8'h4E, 10'b1010011100, "b2b_N");
    tx_frame(8'h44, 10'b1010001000, "b2b_D");
  endtask

  task automatic test_ignore_send;
    bit ok;
    int activity;
    send_byte(8'h00, "ignore");
    wait_start("ignore", ok);
    if (ok) check_frame(10'b1000000000, "ignore_0x00", 1'b1);
    activity = 0;
    for (int k = 0; k < 3 * DIV; k++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) activity++;
    end
    checks++;
    if (activity != 0) $display("FAIL ignore_no_second_frame: active cycles=%0d, required 0", activity);
    else passes++;
  endtask

  task automatic test_reset_midframe;
    bit ok;
    send_byte(8'hA5, "rst_mid");
    wait_start("rst_mid", ok);
    for (int k = 0; k < 4 * DIV + 5; k++) @(negedge clk);
    checks++;
    if (tx !== 1'b0) $display("FAIL rst_mid_data_bit3: tx=%b, required 0", tx);
    else passes++;
    reset = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || baud_tick !== 1'b0)
      $display("FAIL rst_mid_async: tx=%b busy=%b tick=%b, required 1 0 0", tx, busy, baud_tick);
    else passes++;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    tx_frame(8'h3C, 10'b1001111000, "after_reset_0x3C");
  endtask

  task automatic test_edge_bytes;
    tx_frame(8'h00, 10'b1000000000, "edge_0x00");
    tx_frame(8'hFF, 10'b1111111110, "edge_0xFF");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_ignore_send();
    test_reset_midframe();
    test_edge_bytes();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
